// File: rtl/value_stepper.sv
// Purpose : button/switch front end producing the 4-bit operand A for the divisibility indicator.
// Latency : a held button moves A DEBOUNCE_CYCLES+3 edges after its first high sample; an auto step lands AUTO_DIV edges after auto_en rises.
// Backpressure: none; the downstream indicator is a pure decoder, so every event is applied the cycle it is ready.
// Ports   : clk/rst (sync, active-high); btn_step/btn_load raw buttons; sw_val load value;
//           dir (1=up, 0=down); auto_en free-run enable; A operand out; step_pulse one-cycle change strobe.
module value_stepper #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned AUTO_DIV        = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_step,
   input  logic       btn_load,
   input  logic [3:0] sw_val,
   input  logic       dir,
   input  logic       auto_en,
   output logic [3:0] A,
   output logic       step_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PW = $clog2(AUTO_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(AUTO_DIV - 1);

   // Bit 0 is the step button, bit 1 the load button.
   logic [1:0]         s1_q, s2_q;
   logic [1:0]         db_q, db_d;
   logic [1:0]         db_prev_q;
   logic [1:0]         ev_q, ev_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]      pcnt_q, pcnt_d;
   logic               tick_q, tick_d;
   logic [3:0]         a_q, a_d;
   logic               pulse_q, pulse_d;

   // Debounce: the synchronized level must disagree with the accepted level
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Rising edges only; the event is registered before it reaches A.
   assign ev_d = db_q & ~db_prev_q;

   // Prescaler is parked at zero whenever auto mode is off, so re-enabling
   // always waits a full AUTO_DIV period before the first step.
   always_comb begin
      pcnt_d = '0;
      tick_d = 1'b0;
      if (auto_en) begin
         if (pcnt_q == PCNT_LAST) begin
            tick_d = 1'b1;
         end else begin
            pcnt_d = pcnt_q + PW'(1);
         end
      end
   end

   // Load beats step/auto; a simultaneous step is dropped, not queued.
   always_comb begin
      a_d     = a_q;
      pulse_d = 1'b0;
      if (ev_q[1]) begin
         a_d     = sw_val;
         pulse_d = 1'b1;
      end else if (ev_q[0] || tick_q) begin
         a_d     = dir ? a_q + 4'd1 : a_q - 4'd1;
         pulse_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         cnt_q     <= '0;
         ev_q      <= '0;
         pcnt_q    <= '0;
         tick_q    <= 1'b0;
         a_q       <= '0;
         pulse_q   <= 1'b0;
      end else begin
         s1_q      <= {btn_load, btn_step};
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         ev_q      <= ev_d;
         pcnt_q    <= pcnt_d;
         tick_q    <= tick_d;
         a_q       <= a_d;
         pulse_q   <= pulse_d;
      end
   end

   assign A          = a_q;
   assign step_pulse = pulse_q;

endmodule
